// File: rtl/alu_rs_pkg.sv
// Shared widths, encodings and entry layout for the ALU reservation station.
package alu_rs_pkg;

  localparam int DATA_W  = 32;
  localparam int TAG_W   = 5;
  localparam int NAME_W  = 5;
  localparam int OP_W    = 5;
  localparam int ADDR_W  = 32;
  localparam int RS_SIZE = 8;
  localparam int IDX_W   = 3;

  // Tag layout: bit4 = operand already valid, bit3 = producer class (0 ALU, 1 LS),
  // bits[2:0] = producer entry.
  localparam logic [TAG_W-1:0]  TAG_FREE  = 5'b10000;
  localparam logic [DATA_W-1:0] DATA_FREE = '0;
  localparam logic [NAME_W-1:0] NAME_FREE = '0;
  localparam logic [OP_W-1:0]   NOP       = '0;
  localparam logic              ENABLE    = 1'b1;
  localparam logic              DISABLE   = 1'b0;

  // One operand slot: either a pending producer tag or a value tagged TAG_FREE.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } operand_t;

  // One result broadcast bus.
  typedef struct packed {
    logic              en;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;

  // Payload of a reservation-station entry (control bits are held separately).
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    operand_t          opnd_o;
    operand_t          opnd_t;
    logic [TAG_W-1:0]  tag_w;
    logic [NAME_W-1:0] name_w;
  } rs_entry_t;

  // Resolve a pending operand against both broadcast buses. A value that is
  // already valid is never overwritten, even if its data happens to match a tag.
  function automatic operand_t snoop(input operand_t cur, input cdb_t alu_cdb,
                                     input cdb_t ls_cdb);
    operand_t res;
    res = cur;
    if (cur.tag != TAG_FREE) begin
      if (alu_cdb.en && (cur.tag == alu_cdb.tag)) begin
        res.tag  = TAG_FREE;
        res.data = alu_cdb.data;
      end else if (ls_cdb.en && (cur.tag == ls_cdb.tag)) begin
        res.tag  = TAG_FREE;
        res.data = ls_cdb.data;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_pick.sv
// Find-first selector: lowest-index set bit of the ready vector.
module rs_pick
  import alu_rs_pkg::*;
(
  input  logic [RS_SIZE-1:0] ready,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  // Scan from the top down so the lowest ready index is the last one written.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    idx   = '0;
    valid = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Eight-entry reservation station for the ALU: accepts dispatched instructions,
// snoops both result buses for missing operands and issues one ready entry per cycle.
module alu_rs
  import alu_rs_pkg::*;
(
  input  logic                clk,
  input  logic                rst,

  input  logic                ALUen,
  input  logic [DATA_W-1:0]   ALUoperandO,
  input  logic [DATA_W-1:0]   ALUoperandT,
  input  logic [TAG_W-1:0]    ALUtagO,
  input  logic [TAG_W-1:0]    ALUtagT,
  input  logic [TAG_W-1:0]    ALUtagW,
  input  logic [NAME_W-1:0]   ALUnameW,
  input  logic [OP_W-1:0]     ALUop,
  input  logic [ADDR_W-1:0]   ALUaddr,

  input  logic                enALUCDB,
  input  logic [TAG_W-1:0]    ALUCDBtag,
  input  logic [DATA_W-1:0]   ALUCDBdata,
  input  logic                enLSCDB,
  input  logic [TAG_W-1:0]    LSCDBtag,
  input  logic [DATA_W-1:0]   LSCDBdata,

  output logic [RS_SIZE-1:0]  ALUfreeStatus,

  output logic                exEn,
  output logic [DATA_W-1:0]   exOperandO,
  output logic [DATA_W-1:0]   exOperandT,
  output logic [OP_W-1:0]     exOp,
  output logic [ADDR_W-1:0]   exAddr,
  output logic [TAG_W-1:0]    exTagW,
  output logic [NAME_W-1:0]   exNameW
);

  // Control state: busy = entry allocated; issued = entry sent to the ALU at the
  // last edge and released at the next one, so the dispatcher sees it free the
  // cycle after exEn.
  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] issued;
  logic [RS_SIZE-1:0] ready;
  rs_entry_t          entry [RS_SIZE];

  cdb_t               alu_cdb;
  cdb_t               ls_cdb;
  rs_entry_t          in_entry;
  logic [IDX_W-1:0]   dispatch_idx;
  logic               dispatch_ok;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;

  assign alu_cdb = '{en: enALUCDB, tag: ALUCDBtag, data: ALUCDBdata};
  assign ls_cdb  = '{en: enLSCDB,  tag: LSCDBtag,  data: LSCDBdata};

  // A dispatch into an occupied entry is a dispatcher error and is dropped.
  assign dispatch_idx = ALUtagW[IDX_W-1:0];
  assign dispatch_ok  = ALUen && !busy[dispatch_idx];

  // Build the incoming entry, applying same-cycle broadcast bypass to each operand.
  always_comb begin
    in_entry.op     = ALUop;
    in_entry.addr   = ALUaddr;
    in_entry.opnd_o = snoop('{tag: ALUtagO, data: ALUoperandO}, alu_cdb, ls_cdb);
    in_entry.opnd_t = snoop('{tag: ALUtagT, data: ALUoperandT}, alu_cdb, ls_cdb);
    in_entry.tag_w  = ALUtagW;
    in_entry.name_w = ALUnameW;
  end

  // Ready uses registered tags only; a broadcast wakes an entry one edge later.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy[i] && !issued[i] &&
                 (entry[i].opnd_o.tag == TAG_FREE) &&
                 (entry[i].opnd_t.tag == TAG_FREE);
    end
  end

  rs_pick u_pick (
    .ready (ready),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Allocation, issue marking and release of entries.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every entry sees pre-edge state regardless of loop order.
    if (rst) begin
      busy   <= '0;
      issued <= '0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (issued[i]) begin
          busy[i]   <= 1'b0;
          issued[i] <= 1'b0;
        end else if (pick_valid && (pick_idx == IDX_W'(i))) begin
          issued[i] <= 1'b1;
        end else if (dispatch_ok && (dispatch_idx == IDX_W'(i))) begin
          busy[i] <= 1'b1;
        end
      end
    end
  end

  // Entry payload: written on dispatch, otherwise busy entries snoop the broadcasts.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is deliberately not reset; busy gates every use of it.
    for (int i = 0; i < RS_SIZE; i++) begin
      if (dispatch_ok && (dispatch_idx == IDX_W'(i))) begin
        entry[i] <= in_entry;
      end else if (busy[i]) begin
        entry[i].opnd_o <= snoop(entry[i].opnd_o, alu_cdb, ls_cdb);
        entry[i].opnd_t <= snoop(entry[i].opnd_t, alu_cdb, ls_cdb);
      end
    end
  end

  // Issue register: loads the selected entry, holds the last values when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      exEn       <= DISABLE;
      exOperandO <= DATA_FREE;
      exOperandT <= DATA_FREE;
      exOp       <= NOP;
      exAddr     <= '0;
      exTagW     <= TAG_FREE;
      exNameW    <= NAME_FREE;
    end else begin
      exEn <= pick_valid ? ENABLE : DISABLE;
      if (pick_valid) begin
        exOperandO <= entry[pick_idx].opnd_o.data;
        exOperandT <= entry[pick_idx].opnd_t.data;
        exOp       <= entry[pick_idx].op;
        exAddr     <= entry[pick_idx].addr;
        exTagW     <= entry[pick_idx].tag_w;
        exNameW    <= entry[pick_idx].name_w;
      end
    end
  end

  assign ALUfreeStatus = ~busy;

endmodule

// File: tb/tb_alu_rs.sv
// Directed self-checking bench for alu_rs: a table of single ready dispatches
// followed by hand-written wake-up, ordering, full-station and reset sequences.
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst;
  logic        ALUen;
  logic [31:0] ALUoperandO, ALUoperandT, ALUaddr;
  logic [4:0]  ALUtagO, ALUtagT, ALUtagW, ALUnameW, ALUop;
  logic        enALUCDB, enLSCDB;
  logic [4:0]  ALUCDBtag, LSCDBtag;
  logic [31:0] ALUCDBdata, LSCDBdata;
  logic [7:0]  ALUfreeStatus;
  logic        exEn;
  logic [31:0] exOperandO, exOperandT, exAddr;
  logic [4:0]  exOp, exTagW, exNameW;

  localparam logic [4:0] TFREE = 5'b10000;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_rs dut (
    .clk           (clk),
    .rst           (rst),
    .ALUen         (ALUen),
    .ALUoperandO   (ALUoperandO),
    .ALUoperandT   (ALUoperandT),
    .ALUtagO       (ALUtagO),
    .ALUtagT       (ALUtagT),
    .ALUtagW       (ALUtagW),
    .ALUnameW      (ALUnameW),
    .ALUop         (ALUop),
    .ALUaddr       (ALUaddr),
    .enALUCDB      (enALUCDB),
    .ALUCDBtag     (ALUCDBtag),
    .ALUCDBdata    (ALUCDBdata),
    .enLSCDB       (enLSCDB),
    .LSCDBtag      (LSCDBtag),
    .LSCDBdata     (LSCDBdata),
    .ALUfreeStatus (ALUfreeStatus),
    .exEn          (exEn),
    .exOperandO    (exOperandO),
    .exOperandT    (exOperandT),
    .exOp          (exOp),
    .exAddr        (exAddr),
    .exTagW        (exTagW),
    .exNameW       (exNameW)
  );

  typedef struct {
    logic [4:0]  tag_w;
    logic [4:0]  op;
    logic [4:0]  name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ALUen = 1'b0; ALUoperandO = '0; ALUoperandT = '0; ALUaddr = '0;
    ALUtagO = TFREE; ALUtagT = TFREE; ALUtagW = '0; ALUnameW = '0; ALUop = '0;
    enALUCDB = 1'b0; ALUCDBtag = '0; ALUCDBdata = '0;
    enLSCDB = 1'b0; LSCDBtag = '0; LSCDBdata = '0;
  endtask

  task automatic dispatch(input logic [4:0] tag_w, input logic [4:0] op,
                          input logic [4:0] tag_o, input logic [31:0] a,
                          input logic [4:0] tag_t, input logic [31:0] b);
    ALUen = 1'b1; ALUtagW = tag_w; ALUop = op; ALUnameW = tag_w;
    ALUaddr = {27'd0, tag_w} << 2;
    ALUtagO = tag_o; ALUoperandO = a; ALUtagT = tag_t; ALUoperandT = b;
  endtask

  initial begin
    int idx;

    vecs[0] = '{tag_w: 5'b00010, op: 5'd1,  name: 5'd3,  a: 32'd5,          b: 32'd7,          addr: 32'h0000_0100};
    vecs[1] = '{tag_w: 5'b00000, op: 5'd2,  name: 5'd9,  a: 32'hFFFF_FFFF, b: 32'h0000_0000, addr: 32'h0000_0104};
    vecs[2] = '{tag_w: 5'b00111, op: 5'd17, name: 5'd31, a: 32'h8000_0000, b: 32'h7FFF_FFFF, addr: 32'hFFFF_FFFC};
    vecs[3] = '{tag_w: 5'b01101, op: 5'd31, name: 5'd1,  a: 32'h1234_5678, b: 32'hA5A5_A5A5, addr: 32'h0000_2000};

    // Reset state, with a dispatch and a broadcast held active during reset.
    clear_inputs();
    rst = 1'b1;
    dispatch(5'b00100, 5'd3, TFREE, 32'd1, TFREE, 32'd2);
    tick();
    tick();
    rst = 1'b0;
    clear_inputs();
    check("rst_free",   {24'd0, ALUfreeStatus}, 32'h0000_00FF);
    check("rst_exen",   {31'd0, exEn}, 32'd0);
    check("rst_opo",    exOperandO, 32'd0);
    check("rst_opt",    exOperandT, 32'd0);
    check("rst_op",     {27'd0, exOp}, 32'd0);
    check("rst_addr",   exAddr, 32'd0);
    check("rst_tagw",   {27'd0, exTagW}, {27'd0, TFREE});
    check("rst_namew",  {27'd0, exNameW}, 32'd0);
    tick();
    check("rst_noissue", {31'd0, exEn}, 32'd0);

    // Table: fully ready dispatch at cycle 0 -> exEn in cycle 2, entry free from cycle 3.
    for (int v = 0; v < 4; v++) begin
      idx = int'(vecs[v].tag_w[2:0]);
      ALUen = 1'b1; ALUtagW = vecs[v].tag_w; ALUop = vecs[v].op; ALUnameW = vecs[v].name;
      ALUaddr = vecs[v].addr; ALUoperandO = vecs[v].a; ALUoperandT = vecs[v].b;
      ALUtagO = TFREE; ALUtagT = TFREE;
      tick();
      clear_inputs();
      check("vec_en_c1",   {31'd0, exEn}, 32'd0);
      check("vec_busy_c1", {31'd0, ALUfreeStatus[idx]}, 32'd0);
      tick();
      check("vec_en_c2",   {31'd0, exEn}, 32'd1);
      check("vec_opo",     exOperandO, vecs[v].a);
      check("vec_opt",     exOperandT, vecs[v].b);
      check("vec_op",      {27'd0, exOp}, {27'd0, vecs[v].op});
      check("vec_addr",    exAddr, vecs[v].addr);
      check("vec_tagw",    {27'd0, exTagW}, {27'd0, vecs[v].tag_w});
      check("vec_namew",   {27'd0, exNameW}, {27'd0, vecs[v].name});
      check("vec_busy_c2", {31'd0, ALUfreeStatus[idx]}, 32'd0);
      tick();
      check("vec_en_c3",   {31'd0, exEn}, 32'd0);
      check("vec_free_c3", {24'd0, ALUfreeStatus}, 32'h0000_00FF);
      check("vec_hold_c3", exOperandO, vecs[v].a);
    end

    // Wake-up from the load bus: wait on 5'b01011, broadcast in cycle 4 -> exEn cycle 6.
    dispatch(5'b00000, 5'd4, 5'b01011, 32'hDEAD_0000, TFREE, 32'd3);
    tick();
    clear_inputs();
    tick();
    tick();
    tick();
    check("ls_wait_c4", {31'd0, exEn}, 32'd0);
    enLSCDB = 1'b1; LSCDBtag = 5'b01011; LSCDBdata = 32'h0000_1234;
    tick();
    clear_inputs();
    check("ls_wait_c5", {31'd0, exEn}, 32'd0);
    tick();
    check("ls_en_c6",  {31'd0, exEn}, 32'd1);
    check("ls_opo_c6", exOperandO, 32'h0000_1234);
    check("ls_opt_c6", exOperandT, 32'd3);
    tick();
    tick();

    // Write-time bypass from the ALU bus: operand T captured from the broadcast.
    dispatch(5'b00101, 5'd6, TFREE, 32'd4, 5'b00001, 32'hDEAD_BEEF);
    enALUCDB = 1'b1; ALUCDBtag = 5'b00001; ALUCDBdata = 32'd9;
    tick();
    clear_inputs();
    check("byp_en_c1", {31'd0, exEn}, 32'd0);
    tick();
    check("byp_en_c2", {31'd0, exEn}, 32'd1);
    check("byp_opt",   exOperandT, 32'd9);
    check("byp_opo",   exOperandO, 32'd4);
    tick();
    tick();

    // Entries 6, 3, 1 wake together -> issue order 1, 3, 6 on consecutive cycles.
    dispatch(5'b00110, 5'd8, 5'b00100, 32'd0, TFREE, 32'd60);
    tick();
    dispatch(5'b00011, 5'd9, 5'b00100, 32'd0, TFREE, 32'd30);
    tick();
    dispatch(5'b00001, 5'd10, 5'b00100, 32'd0, TFREE, 32'd10);
    tick();
    clear_inputs();
    enALUCDB = 1'b1; ALUCDBtag = 5'b00100; ALUCDBdata = 32'h77;
    tick();
    clear_inputs();
    check("ord_en_c4", {31'd0, exEn}, 32'd0);
    tick();
    check("ord_en_1",   {31'd0, exEn}, 32'd1);
    check("ord_tag_1",  {27'd0, exTagW}, 32'd1);
    check("ord_opt_1",  exOperandT, 32'd10);
    tick();
    check("ord_en_3",   {31'd0, exEn}, 32'd1);
    check("ord_tag_3",  {27'd0, exTagW}, 32'd3);
    tick();
    check("ord_en_6",   {31'd0, exEn}, 32'd1);
    check("ord_tag_6",  {27'd0, exTagW}, 32'd6);
    check("ord_opo_6",  exOperandO, 32'h77);
    tick();
    check("ord_en_end", {31'd0, exEn}, 32'd0);
    tick();

    // Fill all eight entries waiting on 5'b01000; a write to a busy entry is dropped.
    for (int i = 0; i < 8; i++) begin
      dispatch(5'(i), 5'(i + 1), 5'b01000, 32'd0, TFREE, 32'h100 + 32'(i) * 32'h10);
      tick();
    end
    clear_inputs();
    check("full_free", {24'd0, ALUfreeStatus}, 32'd0);
    dispatch(5'b00011, 5'd20, TFREE, 32'hBAD0, TFREE, 32'hBAD1);
    tick();
    clear_inputs();
    check("full_drop_en",   {31'd0, exEn}, 32'd0);
    check("full_drop_free", {24'd0, ALUfreeStatus}, 32'd0);
    enLSCDB = 1'b1; LSCDBtag = 5'b01000; LSCDBdata = 32'hCAFE;
    tick();
    clear_inputs();
    check("full_en_pre", {31'd0, exEn}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("full_en",  {31'd0, exEn}, 32'd1);
      check("full_tag", {27'd0, exTagW}, 32'(k));
      check("full_op",  {27'd0, exOp}, 32'(k + 1));
      check("full_opo", exOperandO, 32'hCAFE);
      check("full_opt", exOperandT, 32'h100 + 32'(k) * 32'h10);
    end
    tick();
    check("full_en_end",   {31'd0, exEn}, 32'd0);
    check("full_free_end", {24'd0, ALUfreeStatus}, 32'h0000_00FF);

    // Reset mid-operation with three busy entries, a dispatch and a matching broadcast.
    dispatch(5'b00000, 5'd1, 5'b01111, 32'd0, TFREE, 32'd1);
    tick();
    dispatch(5'b00010, 5'd2, 5'b01111, 32'd0, TFREE, 32'd2);
    tick();
    dispatch(5'b00100, 5'd3, TFREE, 32'd0, 5'b01111, 32'd3);
    tick();
    clear_inputs();
    check("mid_free_pre", {24'd0, ALUfreeStatus}, 32'h0000_00EA);
    rst = 1'b1;
    dispatch(5'b00111, 5'd4, TFREE, 32'd5, TFREE, 32'd6);
    enALUCDB = 1'b1; ALUCDBtag = 5'b01111; ALUCDBdata = 32'h55;
    tick();
    rst = 1'b0;
    clear_inputs();
    check("mid_free", {24'd0, ALUfreeStatus}, 32'h0000_00FF);
    check("mid_exen", {31'd0, exEn}, 32'd0);
    enALUCDB = 1'b1; ALUCDBtag = 5'b01111; ALUCDBdata = 32'h66;
    tick();
    clear_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_noissue", {31'd0, exEn}, 32'd0);
    end
    check("mid_free_end", {24'd0, ALUfreeStatus}, 32'h0000_00FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 ALUen  input  1  dispatch valid from dispatcher, one entry per cycle max.
REQ-004 ALUoperandO / ALUoperandT  input  32 each  operand data, meaningful only when matching tag = tagFree.
REQ-005 ALUtagO / ALUtagT  input  5 each  producer tags of operands; tagFree = operand already valid.
REQ-006 ALUtagW  input  5  allocated destination tag; bits[2:0] select the RS entry index.
REQ-007 ALUnameW  input  5  destination register name; ALUop  input  5  opcode; ALUaddr  input  32  instruction address.
REQ-008 enALUCDB, ALUCDBtag, ALUCDBdata  input  1/5/32  ALU result broadcast.
REQ-009 enLSCDB, LSCDBtag, LSCDBdata  input  1/5/32  load result broadcast.
REQ-010 ALUfreeStatus  output  8  bit i = 1 when entry i is free; returned to dispatcher tag table.
REQ-011 exEn  output  1  issue valid to ALU for one cycle.
REQ-012 exOperandO, exOperandT  output  32 each; exOp  output  5; exAddr  output  32; exTagW  output  5; exNameW  output  5.

Function
REQ-013 Eight entries; each holds busy, op, addr, two data fields, two tags, dest tag, dest name.
REQ-014 Tag encoding: bit4 = free flag (tagFree = 5'b10000), bit3 = prefix (0 ALU, 1 LS), bits[2:0] = root.
REQ-015 ALUen=1 and entry ALUtagW[2:0] not busy -> entry written at that edge, busy set.
REQ-016 ALUen=1 targeting a busy entry -> write dropped, entry unchanged (dispatcher contract violation, must not corrupt).
REQ-017 Write-time bypass: incoming operand whose tag equals an enabled CDB tag in the same cycle is stored with CDB data and tagFree.
REQ-018 Snoop: every busy entry operand with tag == enabled CDB tag captures CDB data and becomes tagFree at that edge; both CDBs may hit different operands/entries in one cycle.
REQ-019 An entry is ready when busy and both stored tags == tagFree (registered state only, no same-cycle CDB wake-up).
REQ-020 Issue: each cycle, lowest-index ready entry is selected; at edge, ex* outputs load its fields, exEn=1, its busy cleared.
REQ-021 No ready entry -> exEn=0 next cycle, ex* data outputs hold previous values.
REQ-022 Latency: dispatch of fully-ready instruction at cycle N -> exEn=1 in cycle N+2; CDB capture in cycle C -> earliest exEn in C+2.
REQ-023 ALUfreeStatus = ~busy, combinational from registers; freed entry reads free the cycle after issue.
REQ-024 All 8 busy: ALUfreeStatus = 0; dispatcher must not assert ALUen; issue continues normally.
REQ-025 Throughput: one issue per cycle; dispatch and issue of different entries in same cycle both take effect.
REQ-026 No flush port this revision; issued instructions are never cancelled.

Reset
REQ-027 rst=1 at a clock edge: all busy cleared, ALUfreeStatus = 8'hFF, exEn=0, exOperandO/T=dataFree, exOp=NOP, exTagW=tagFree, exNameW=nameFree, exAddr=0.
REQ-028 Reset overrides simultaneous ALUen and CDB inputs; reset mid-operation discards all entries.

Structure
REQ-029 Widths (DataBus, TagBus, NameBus, OpBus, InstAddrBus, rsSize), tagFree, dataFree, nameFree, NOP, Enable/Disable live in defines.v.
REQ-030 One sub-module rs_pick: combinational find-first over 8 ready bits -> 3-bit index plus any-ready flag.

Verification
REQ-031 Dispatch ADD tags both tagFree, data 5/7, ALUtagW=5'b00010 at cycle 0 -> exEn=1 cycle 2, exOperandO=5, exOperandT=7, ALUfreeStatus[2]=0 cycles 1-2, 1 from cycle 3.
REQ-032 Dispatch entry 0 with ALUtagO=5'b01011; enLSCDB tag 5'b01011 data 0x1234 cycle 4 -> exEn cycle 6, exOperandO=0x1234.
REQ-033 Dispatch with ALUtagT=5'b00001 while enALUCDB tag 5'b00001 data 9 same cycle -> bypass, exEn two cycles later, exOperandT=9.
REQ-034 Entries 1, 3, 6 all ready simultaneously -> exEn three consecutive cycles, order 1, 3, 6.
REQ-035 Fill all 8 entries waiting on tag 5'b01000 -> ALUfreeStatus=0; broadcast it once -> eight consecutive issues; ALUen to busy entry drops write.
REQ-036 rst asserted with 3 busy entries and ALUen=1 -> next cycle ALUfreeStatus=8'hFF, exEn=0, no later issue.
